// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_arbiter
// Purpose  : Shared WIDTH-bit bank of JK storage bits. Two requesters (A, B)
//            compete through a round-robin arbiter. Each granted command
//            applies JK semantics to one addressed bit:
//            00 hold, 01 clear, 10 set, 11 toggle.
//            A toggle can repeat cnt times as a multi-cycle burst.
// Ports    : clk, rst (async, active-high)
//            req_x/jk_x/idx_x/cnt_x   command inputs for requester x (a/b)
//            gnt_x                    registered one-cycle grant pulse
//            q                        bank contents
//            q_par                    even parity of q (JK_BANK_PARITY_EN only)
//            busy                     high while a command executes
//            done                     one-cycle pulse after the final apply
// Options  : `define JK_BANK_PARITY_EN adds the registered q_par output.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [1:0]       jk_a,
    input  logic [IDXW-1:0]  idx_a,
    input  logic [CNTW-1:0]  cnt_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [1:0]       jk_b,
    input  logic [IDXW-1:0]  idx_b,
    input  logic [CNTW-1:0]  cnt_b,
    output logic             gnt_b,
    output logic [WIDTH-1:0] q,
`ifdef JK_BANK_PARITY_EN
    output logic             q_par,
`endif
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic [1:0]       c_jk_hold = 2'b00;
    localparam logic [1:0]       c_jk_clr  = 2'b01;
    localparam logic [1:0]       c_jk_set  = 2'b10;
    localparam logic [1:0]       c_jk_tgl  = 2'b11;
    localparam logic [CNTW-1:0]  c_cnt_one = CNTW'(1);
    localparam logic [WIDTH-1:0] c_bit0    = WIDTH'(1);

    state_t           r_state;
    logic             r_prio;     // 0: A holds priority, 1: B holds priority
    logic [1:0]       r_jk;
    logic [IDXW-1:0]  r_idx;
    logic [CNTW-1:0]  r_cnt;      // latched count, then remaining toggles

    state_t           w_state_nxt;
    logic             w_prio_nxt;
    logic [1:0]       w_jk_nxt;
    logic [IDXW-1:0]  w_idx_nxt;
    logic [CNTW-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_gnt_a_nxt;
    logic             w_gnt_b_nxt;
    logic             w_done_nxt;
    logic             w_win_a;
    logic             w_win_b;
    logic [WIDTH-1:0] w_mask;

    // A wins when alone or when it holds priority; B wins otherwise.
    assign w_win_a = req_a & (~req_b | ~r_prio);
    assign w_win_b = req_b & ~w_win_a;

    // Shifting past the top bit yields an all-zero mask, so an out-of-range
    // index naturally leaves q untouched while timing stays unchanged.
    assign w_mask = c_bit0 << r_idx;

    assign busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_jk_nxt    = r_jk;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = q;
        w_gnt_a_nxt = 1'b0;
        w_gnt_b_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_a) begin
                    w_jk_nxt    = jk_a;
                    w_idx_nxt   = idx_a;
                    w_cnt_nxt   = cnt_a;
                    w_gnt_a_nxt = 1'b1;
                    w_prio_nxt  = 1'b1;
                    w_state_nxt = ST_APPLY;
                end else if (w_win_b) begin
                    w_jk_nxt    = jk_b;
                    w_idx_nxt   = idx_b;
                    w_cnt_nxt   = cnt_b;
                    w_gnt_b_nxt = 1'b1;
                    w_prio_nxt  = 1'b0;
                    w_state_nxt = ST_APPLY;
                end
            end

            ST_APPLY: begin
                case (r_jk)
                    c_jk_hold: w_q_nxt = q;
                    c_jk_clr:  w_q_nxt = q & ~w_mask;
                    c_jk_set:  w_q_nxt = q | w_mask;
                    default:   w_q_nxt = q ^ w_mask;
                endcase
                // cnt of 0 or 1 means a single toggle, so only larger counts burst.
                if ((r_jk == c_jk_tgl) && (r_cnt > c_cnt_one)) begin
                    w_cnt_nxt   = r_cnt - c_cnt_one;
                    w_state_nxt = ST_BURST;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_BURST: begin
                w_q_nxt   = q ^ w_mask;
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_jk    <= 2'b00;
            r_idx   <= '0;
            r_cnt   <= '0;
            q       <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_jk    <= w_jk_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            q       <= w_q_nxt;
            gnt_a   <= w_gnt_a_nxt;
            gnt_b   <= w_gnt_b_nxt;
            done    <= w_done_nxt;
        end
    end

`ifdef JK_BANK_PARITY_EN
    // Parity is taken from the next q so it lines up with q in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_par <= 1'b0;
        end else begin
            q_par <= ^w_q_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
